truth_table_checker: RTL and testbench
======================================

# truth_table_checker

Self-contained hardware test engine for small combinational DUTs in the autograder flow. It sweeps every input combination of an N-input, 1-output DUT, waits a fixed settle time, samples the DUT output and compares it against a parameterised golden truth table. It reports completion, overall pass/fail, a mismatch count and the first failing vector. It sits beside the DUT as the driving and checking end of the same a/b/out interface, replacing per-gate hand-written stimulus benches.

## Interface
Parameters:
- `N_IN`, default 2: number of DUT inputs. Legal range 1..8.
- `EXPECTED`, default 4'b1000: golden truth table, width 2**N_IN. Bit v is the required DUT output for input vector v. The default is AND.
- `SETTLE`, default 1: cycles each vector is held before sampling. Legal range 1..255.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a sweep. Sampled in IDLE or DONE.
- `dut_in` out N_IN: vector driven to the DUT inputs. Bit 0 maps to the last-listed DUT input (b); bit N_IN-1 maps to the first (a).
- `dut_out` in 1: DUT output under test.
- `busy` out 1: sweep in progress.
- `done` out 1: sweep finished. Held until the next accepted start or reset.
- `pass` out 1: valid when done=1. High iff err_count==0.
- `err_count` out N_IN+1: number of mismatching vectors. Saturation is not needed; the maximum is 2**N_IN.
- `first_fail_valid` out 1: at least one mismatch recorded.
- `first_fail_vec` out N_IN: lowest-numbered failing vector.

## Operation
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE:
  - start=1 → DRIVE.
  - On entry to DRIVE: vec=0, settle_cnt=0, err_count=0, first_fail_valid=0, first_fail_vec=0.
- DRIVE:
  - dut_in=vec.
  - settle_cnt increments each cycle.
  - When settle_cnt==SETTLE-1 → CHECK.
- CHECK:
  - dut_in is still vec.
  - Compare dut_out against EXPECTED[vec].
  - On mismatch: err_count+1. If first_fail_valid==0, set first_fail_vec=vec and first_fail_valid=1.
  - If vec==2**N_IN-1 → DONE.
  - Otherwise vec+1, settle_cnt=0 → DRIVE.
- DONE:
  - done=1; pass=(err_count==0).
  - Outputs are frozen.
  - start=1 → DRIVE, with the same clears as from IDLE.
- start is ignored in DRIVE and CHECK. No restart mid-sweep.
- dut_out is sampled only in CHECK. X or Z on dut_out counts as a mismatch in simulation (use a case-equality compare).
- vec is an N_IN+1-bit counter internally. The last-vector check uses the full value, so the sweep terminates for N_IN=8.

## Timing
- Reset values: dut_in=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_vec=0; state=IDLE.
- reset takes priority over start and over every state, including mid-sweep. The next cycle is IDLE with all outputs at reset values.
- start accepted at edge t: busy=1 from t+1; dut_in=0 from t+1.
- Each vector occupies SETTLE+1 cycles: SETTLE in DRIVE plus 1 in CHECK.
- done rises at edge t + 2**N_IN*(SETTLE+1) + 1. On that same edge busy falls.
- busy and done are never high together. busy=1 exactly in DRIVE and CHECK.
- err_count and the first-fail fields update at the CHECK edge. They are visible the following cycle.
- start coinciding with the edge that enters DONE is ignored. The engine must be observed in DONE before a restart.

## Structure
- Shared package `tt_check_pkg`:
  - state enum `tt_state_t` {IDLE, DRIVE, CHECK, DONE}.
  - constant `SETTLE_W=8`.
  - function `tt_vectors(n)` returning 2**n.
- One natural sub-module: `settle_timer`. It is a loadable down- or up-counter with a terminal-count flag, reusable by later sequential-project checkers (register, PC).
- The FSM, vector counter and scoreboard stay in the top module.

## Test plan
- N_IN=2, EXPECTED=4'b1000, correct AND DUT, SETTLE=1, start pulse:
  - dut_in steps 0,1,2,3, two cycles each.
  - done at start+9 cycles.
  - pass=1, err_count=0, first_fail_valid=0.
- Same parameters, OR DUT substituted (outputs 0,1,1,1):
  - err_count=2, first_fail_vec=1, first_fail_valid=1, pass=0.
- SETTLE=3, DUT output delayed 2 cycles:
  - pass=1.
  - With SETTLE=1 and the same DUT, mismatches are reported.
- reset asserted during vector 2 CHECK:
  - Next cycle IDLE, all outputs 0.
  - A new start gives a clean full sweep with correct results.
- start held high throughout:
  - No restart while busy.
  - After done, a second sweep begins from DONE and clears err_count before the first CHECK.
- N_IN=3, EXPECTED=8'h80 (3-input AND), dut_out tied 0:
  - err_count=1, first_fail_vec=3'b111.
  - done at start+17 cycles.

Source files
------------

// File: rtl/truth_table_checker_pkg.sv
// Shared types and constants for the truth-table test engines.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package tt_check_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } tt_state_t;

    // Width of the settle counter; holds settle times up to 255 cycles.
    localparam int SETTLE_W = 8;

    // Number of input vectors for an n-input combinational DUT.
    function automatic int tt_vectors(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// Loadable up-counter with a terminal-count flag (settle/dwell timing).
// Latency: tc is combinational from the registered count.
// Backpressure: none; load has priority over en.
//
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   load       - load load_val into the count (priority over en)
//   en         - increment the count by one
//   load_val   - value loaded by load
//   terminal   - count value at which tc is raised
//   tc         - count == terminal
module settle_timer
    import tt_check_pkg::*;
#(
    parameter int W = SETTLE_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] terminal,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == terminal);

endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive truth-table sweep of an N_IN-input, 1-output combinational DUT.
// Latency: 2**N_IN*(SETTLE+1)+1 cycles from the accepted start to done.
// Backpressure: none; start is ignored while busy and is taken only in IDLE or DONE.
//
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   start             - begin a sweep (accepted in IDLE or DONE)
//   dut_in            - vector driven to the DUT (bit N_IN-1 = first DUT input)
//   dut_out           - DUT output under test
//   busy / done       - sweep in progress / sweep finished (held until restart)
//   pass              - done with zero mismatches
//   err_count         - number of mismatching vectors
//   first_fail_valid  - at least one mismatch recorded
//   first_fail_vec    - lowest-numbered failing vector
module truth_table_checker
    import tt_check_pkg::*;
#(
    parameter int                            N_IN     = 2,
    parameter logic [(1 << N_IN)-1:0]        EXPECTED = 4'b1000,
    parameter int                            SETTLE   = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_vec
);

    // vec carries one extra bit so the last-vector compare is exact for N_IN=8.
    localparam logic [N_IN:0]       LAST_VEC  = (N_IN+1)'(tt_vectors(N_IN) - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_TC = SETTLE_W'(SETTLE - 1);

    tt_state_t       state, next_state;
    logic [N_IN:0]   vec;
    logic            accept;
    logic            last_vec;
    logic            mismatch;
    logic            settle_tc;

    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign last_vec = (vec == LAST_VEC);
    // Case inequality so an X or Z DUT output is scored as a failure.
    assign mismatch = (dut_out !== EXPECTED[vec[N_IN-1:0]]);

    // Timer is held at zero outside DRIVE so every vector starts a fresh dwell.
    settle_timer #(.W(SETTLE_W)) u_settle (
        .clk      (clk),
        .reset    (reset),
        .load     (state != DRIVE),
        .en       (state == DRIVE),
        .load_val ('0),
        .terminal (SETTLE_TC),
        .tc       (settle_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)     next_state = DRIVE;
            DRIVE:   if (settle_tc) next_state = CHECK;
            CHECK:   next_state = last_vec ? DONE : DRIVE;
            DONE:    if (start)     next_state = DRIVE;
            default: next_state = IDLE;
        endcase
    end

    // Vector counter and scoreboard.
    always_ff @(posedge clk) begin
        if (reset) begin
            vec              <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else if (accept) begin
            vec              <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else if (state == CHECK) begin
            if (mismatch) begin
                err_count <= err_count + (N_IN+1)'(1);
                if (!first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_vec   <= vec[N_IN-1:0];
                end
            end
            // vec parks on the last vector so dut_in stays frozen in DONE.
            if (!last_vec) begin
                vec <= vec + (N_IN+1)'(1);
            end
        end
    end

    assign dut_in = vec[N_IN-1:0];
    assign busy   = (state == DRIVE) || (state == CHECK);
    assign done   = (state == DONE);
    assign pass   = done && (err_count == '0);

endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_a [4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // ---------------- DUT-side stand-ins ----------------
    logic [3:0] tbl0;       // truth table of the DUT beside instance 0
    logic       dly_mode0;  // instance 0 sees a 2-cycle-delayed AND instead
    logic [7:0] tbl3;
    logic [1:0] dl0, dl1;

    logic [1:0] in0, in1;
    logic [2:0] in2, in3;
    logic [2:0] err0, err1;
    logic [3:0] err2, err3;
    logic [1:0] ffv0, ffv1;
    logic [2:0] ffv2, ffv3;
    logic       busy_w [4], done_w [4], pass_w [4], ffok_w [4];
    logic       dout0, dout1, dout3;

    always @(posedge clk) begin
        dl0 <= {dl0[0], &in0};
        dl1 <= {dl1[0], &in1};
    end

    assign dout0 = dly_mode0 ? dl0[1] : tbl0[in0];
    assign dout1 = dl1[1];
    assign dout3 = tbl3[in3];

    truth_table_checker #(.N_IN(2), .EXPECTED(4'b1000), .SETTLE(1)) u0 (
        .clk(clk), .reset(reset), .start(start_a[0]), .dut_in(in0), .dut_out(dout0),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(err0),
        .first_fail_valid(ffok_w[0]), .first_fail_vec(ffv0));

    truth_table_checker #(.N_IN(2), .EXPECTED(4'b1000), .SETTLE(3)) u1 (
        .clk(clk), .reset(reset), .start(start_a[1]), .dut_in(in1), .dut_out(dout1),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(err1),
        .first_fail_valid(ffok_w[1]), .first_fail_vec(ffv1));

    truth_table_checker #(.N_IN(3), .EXPECTED(8'h80), .SETTLE(1)) u2 (
        .clk(clk), .reset(reset), .start(start_a[2]), .dut_in(in2), .dut_out(1'b0),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_count(err2),
        .first_fail_valid(ffok_w[2]), .first_fail_vec(ffv2));

    truth_table_checker #(.N_IN(3), .EXPECTED(8'h96), .SETTLE(2)) u3 (
        .clk(clk), .reset(reset), .start(start_a[3]), .dut_in(in3), .dut_out(dout3),
        .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]), .err_count(err3),
        .first_fail_valid(ffok_w[3]), .first_fail_vec(ffv3));

    // Uniform-width views so one task can check any instance.
    logic [8:0] in_w [4], err_w [4], ffvec_w [4];
    assign in_w[0] = 9'(in0);   assign in_w[1] = 9'(in1);
    assign in_w[2] = 9'(in2);   assign in_w[3] = 9'(in3);
    assign err_w[0] = 9'(err0); assign err_w[1] = 9'(err1);
    assign err_w[2] = 9'(err2); assign err_w[3] = 9'(err3);
    assign ffvec_w[0] = 9'(ffv0); assign ffvec_w[1] = 9'(ffv1);
    assign ffvec_w[2] = 9'(ffv2); assign ffvec_w[3] = 9'(ffv3);

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input int k, input string tag);
        chk({tag, "_dut_in"}, 32'(in_w[k]), 0);
        chk({tag, "_busy"},   32'(busy_w[k]), 0);
        chk({tag, "_done"},   32'(done_w[k]), 0);
        chk({tag, "_pass"},   32'(pass_w[k]), 0);
        chk({tag, "_err"},    32'(err_w[k]), 0);
        chk({tag, "_ffok"},   32'(ffok_w[k]), 0);
        chk({tag, "_ffvec"},  32'(ffvec_w[k]), 0);
    endtask

    // Reference: mismatches between the DUT's table and the golden table,
    // and the lowest failing vector.
    function automatic void model(input logic [255:0] act, input logic [255:0] gold,
                                  input int nvec, output int err, output int fv,
                                  output int fvec);
        err = 0; fv = 0; fvec = 0;
        for (int v = 0; v < nvec; v++) begin
            if (act[v] != gold[v]) begin
                if (fv == 0) begin
                    fv = 1;
                    fvec = v;
                end
                err++;
            end
        end
    endfunction

    // One full sweep from a start pulse; every cycle is timed exactly:
    // vector v is on dut_in for cycles v*(s+1)+1 .. (v+1)*(s+1) after the start edge.
    task automatic sweep(input int k, input int s, input int nvec, input int e_err,
                         input int e_fv, input int e_vec, input string tag);
        int total;
        total = nvec * (s + 1);
        start_a[k] = 1'b1;
        @(negedge clk);
        start_a[k] = 1'b0;
        for (int n = 1; n <= total; n++) begin
            chk({tag, "_busy"},   32'(busy_w[k]), 1);
            chk({tag, "_done"},   32'(done_w[k]), 0);
            chk({tag, "_dut_in"}, 32'(in_w[k]), 32'((n - 1) / (s + 1)));
            @(negedge clk);
        end
        chk({tag, "_done_at"}, 32'(done_w[k]), 1);
        chk({tag, "_busy_end"}, 32'(busy_w[k]), 0);
        chk({tag, "_err"},     32'(err_w[k]), 32'(e_err));
        chk({tag, "_ffok"},    32'(ffok_w[k]), 32'(e_fv));
        chk({tag, "_ffvec"},   32'(ffvec_w[k]), 32'(e_vec));
        chk({tag, "_pass"},    32'(pass_w[k]), 32'(e_err == 0));
        @(negedge clk);
        chk({tag, "_done_hold"}, 32'(done_w[k]), 1);
        chk({tag, "_err_hold"},  32'(err_w[k]), 32'(e_err));
        chk({tag, "_in_frozen"}, 32'(in_w[k]), 32'(nvec - 1));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int e, fv, fvec;
        for (int k = 0; k < 4; k++) start_a[k] = 1'b0;
        tbl0 = 4'b1000;
        tbl3 = 8'h00;
        dly_mode0 = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) check_idle(k, "reset");
        reset = 1'b0;
        @(negedge clk);

        // Correct AND DUT.
        sweep(0, 1, 4, 0, 0, 0, "and");

        // OR substituted: vectors 1 and 2 fail.
        tbl0 = 4'b1110;
        sweep(0, 1, 4, 2, 1, 1, "or");

        // Two-cycle-late AND with a 3-cycle settle: sampled value is already correct.
        sweep(1, 3, 4, 0, 0, 0, "delay_s3");

        // 3-input AND expected, output tied low: only vector 7 fails.
        sweep(2, 1, 8, 1, 1, 7, "and3_tied0");

        // Reset during the CHECK cycle of vector 2.
        tbl0 = 4'b1000;
        start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("midreset_pre_in", 32'(in_w[0]), 2);
        chk("midreset_pre_busy", 32'(busy_w[0]), 1);
        reset = 1'b1;
        @(negedge clk);
        check_idle(0, "midreset");
        reset = 1'b0;
        @(negedge clk);
        check_idle(0, "midreset_stay");
        sweep(0, 1, 4, 0, 0, 0, "after_reset");

        // start held high: no restart while busy; restart from DONE clears the scoreboard.
        tbl0 = 4'b1110;
        start_a[0] = 1'b1;
        @(negedge clk);
        for (int n = 1; n <= 8; n++) begin
            chk("hold_busy", 32'(busy_w[0]), 1);
            chk("hold_dut_in", 32'(in_w[0]), 32'((n - 1) / 2));
            @(negedge clk);
        end
        chk("hold_done", 32'(done_w[0]), 1);
        chk("hold_err1", 32'(err_w[0]), 2);
        @(negedge clk);
        chk("hold_restart_busy", 32'(busy_w[0]), 1);
        chk("hold_restart_done", 32'(done_w[0]), 0);
        chk("hold_restart_err", 32'(err_w[0]), 0);
        chk("hold_restart_ffok", 32'(ffok_w[0]), 0);
        chk("hold_restart_in", 32'(in_w[0]), 0);
        start_a[0] = 1'b0;
        repeat (8) @(negedge clk);
        chk("hold_done2", 32'(done_w[0]), 1);
        chk("hold_err2", 32'(err_w[0]), 2);
        chk("hold_ffvec2", 32'(ffvec_w[0]), 1);

        // Delayed AND with a 1-cycle settle samples the previous vector's
        // response; from a reset (dut_in=0) only vector 3 reads AND(2)=0.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        dly_mode0 = 1'b1;
        @(negedge clk);
        sweep(0, 1, 4, 1, 1, 3, "delay_s1");
        dly_mode0 = 1'b0;

        // Random DUT truth tables against the reference model.
        for (int r = 0; r < 6; r++) begin
            tbl0 = 4'($urandom);
            model(256'(tbl0), 256'(4'b1000), 4, e, fv, fvec);
            sweep(0, 1, 4, e, fv, fvec, "rand2");
            tbl3 = 8'($urandom);
            model(256'(tbl3), 256'(8'h96), 8, e, fv, fvec);
            sweep(3, 2, 8, e, fv, fvec, "rand3");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
